// File: rtl/jtpopeye_obj_scan.sv
// Sprite line scanner: walks the 256 object slots at each line start and queues
// the objects that cover the requested line, in slot order, for the sprite drawer.
module jtpopeye_obj_scan #(
  parameter int DEPTH = 8,
  parameter int OBJ_H = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        line_start,
  input  logic [7:0]  V,
  output logic [7:0]  obj_addr,
  input  logic [28:0] obj_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_x,
  output logic [7:0]  out_code,
  output logic [4:0]  out_attr,
  output logic [3:0]  out_row,
  output logic        scan_busy,
  output logic        ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SCAN} state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] code;
    logic [4:0] attr;
    logic [3:0] row;
  } entry_t;

  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    vl_q, vl_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic          pv_q, pv_d;       // pipeline valid: obj_data belongs to pslot_q
  logic [7:0]    pslot_q, pslot_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  entry_t        mem_q [DEPTH];

  logic [7:0] diff;
  logic [3:0] row;
  logic       hit, full, pop, push, drop;
  entry_t     new_entry;

  always_comb begin
    diff      = vl_q - obj_data[15:8];
    row       = (obj_data[28] ? ~diff[3:0] : diff[3:0]) & 4'(OBJ_H - 1);
    hit       = (state_q == SCAN) && pv_q && (obj_data[7:0] != 8'd0) && (diff < 8'(OBJ_H));
    full      = (cnt_q == CW'(DEPTH));
    pop       = (cnt_q != '0) && out_ready && !line_start;
    push      = hit && !line_start && (!full || pop);
    drop      = hit && !line_start && full && !pop;
    new_entry = '{x: obj_data[7:0], code: obj_data[23:16], attr: obj_data[28:24], row: row};
  end

  // NOTE: every _d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    vl_d    = vl_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    pv_d    = 1'b0;
    pslot_d = pslot_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (line_start) begin
      state_d = SCAN;
      addr_d  = 8'd0;
      vl_d    = V;
      busy_d  = 1'b1;
      ovf_d   = 1'b0;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
    end else begin
      if (pop)  rd_d = rd_q + AW'(1);
      if (push) wr_d = wr_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (state_q == SCAN) begin
        if (drop) begin
          // Overflow ends the line immediately; queued entries stay for the drawer.
          state_d = IDLE;
          busy_d  = 1'b0;
          ovf_d   = 1'b1;
        end else begin
          pv_d    = 1'b1;
          pslot_d = addr_q;
          if (addr_q != 8'hFF) addr_d = addr_q + 8'd1;
          if (pv_q && pslot_q == 8'hFF) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            pv_d    = 1'b0;
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 8'd0;
      vl_q    <= 8'd0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      pv_q    <= 1'b0;
      pslot_q <= 8'd0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else if (cen) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      vl_q    <= vl_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      pv_q    <= pv_d;
      pslot_q <= pslot_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the FIFO storage has no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && cen && push) mem_q[wr_q] <= new_entry;
  end

  assign obj_addr  = addr_q;
  assign scan_busy = busy_q;
  assign ovf       = ovf_q;
  assign out_valid = (cnt_q != '0);
  assign out_x     = mem_q[rd_q].x;
  assign out_code  = mem_q[rd_q].code;
  assign out_attr  = mem_q[rd_q].attr;
  assign out_row   = mem_q[rd_q].row;

endmodule

// File: tb/tb_jtpopeye_obj_scan.sv
// Self-checking bench for jtpopeye_obj_scan: a line-level model derives the
// expected queue, overflow and address from the object table and the handshake.
module tb_jtpopeye_obj_scan;

  localparam int DEPTH = 8;
  localparam int OBJ_H = 16;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] code;
    logic [4:0] attr;
    logic [3:0] row;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, cen, line_start, out_ready;
  logic [7:0]  V;
  logic [7:0]  obj_addr;
  logic [28:0] obj_data;
  logic        out_valid, scan_busy, ovf;
  logic [7:0]  out_x, out_code;
  logic [4:0]  out_attr;
  logic [3:0]  out_row;

  jtpopeye_obj_scan #(.DEPTH(DEPTH), .OBJ_H(OBJ_H)) dut (
    .clk(clk), .rst(rst), .cen(cen), .line_start(line_start), .V(V),
    .obj_addr(obj_addr), .obj_data(obj_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_code(out_code),
    .out_attr(out_attr), .out_row(out_row), .scan_busy(scan_busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Object buffer: synchronous read, data one cen after the address.
  logic [28:0] obj_mem [256];
  always @(posedge clk) if (cen) obj_data <= obj_mem[obj_addr];

  int   checks = 0;
  int   failures = 0;
  int   dut_pops = 0;
  ent_t m_q[$];
  bit   m_busy, m_ovf;
  int   m_n, m_addr;
  int   m_vl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t make_entry(input logic [28:0] w, input int diff);
    ent_t e;
    int   r;
    r = w[28] ? (15 - diff) : diff;
    e.x    = w[7:0];
    e.code = w[23:16];
    e.attr = w[28:24];
    e.row  = 4'(r % OBJ_H);
    return e;
  endfunction

  // One cen edge of the line-level model: pops first, then the slot due at this edge.
  function automatic void model_edge(input bit ls, input logic [7:0] v, input bit rdy,
                                     input bit ce, input bit r);
    int          slot, diff;
    logic [28:0] w;
    bit          stop;
    if (r) begin
      m_q.delete(); m_busy = 0; m_ovf = 0; m_addr = 0;
      return;
    end
    if (!ce) return;
    if (ls) begin
      m_q.delete(); m_ovf = 0; m_busy = 1; m_addr = 0; m_vl = int'(v); m_n = 0;
      return;
    end
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    if (m_busy) begin
      m_n++;
      stop = 0;
      if (m_n >= 2) begin
        slot = m_n - 2;
        w    = obj_mem[slot];
        diff = (m_vl - int'(w[15:8])) & 255;
        if (w[7:0] != 0 && diff < OBJ_H) begin
          if (m_q.size() < DEPTH) m_q.push_back(make_entry(w, diff));
          else begin
            m_ovf = 1; m_busy = 0; stop = 1;
          end
        end
        if (slot == 255) m_busy = 0;
      end
      if (!stop && m_addr < 255) m_addr++;
    end
  endfunction

  task automatic compare();
    check("valid", 32'(out_valid), 32'(m_q.size() > 0));
    check("busy", 32'(scan_busy), 32'(m_busy));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("addr", 32'(obj_addr), 32'(m_addr));
    if (m_q.size() > 0)
      check("head", 32'({out_x, out_code, out_attr, out_row}), 32'(m_q[0]));
  endtask

  task automatic step(input bit ls, input logic [7:0] v, input bit rdy, input bit ce, input bit r);
    @(negedge clk);
    rst = r; cen = ce; line_start = ls; V = v; out_ready = rdy;
    if (!r && ce && !ls && out_valid && rdy) dut_pops++;
    model_edge(ls, v, rdy, ce, r);
    @(posedge clk);
    #1;
    compare();
  endtask

  // mode: 0 never ready, 1 always ready, 2 toggles per cen, 3 random; jitter adds cen=0 cycles.
  task automatic run(input int ncyc, input int mode, input bit jitter);
    bit rdy, ce, tog;
    tog = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      ce = jitter ? ($urandom_range(0, 9) != 0) : 1'b1;
      case (mode)
        0:       rdy = 1'b0;
        1:       rdy = 1'b1;
        2:       rdy = tog;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (ce) tog = ~tog;
      step(1'b0, 8'd0, rdy, ce, 1'b0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_q.size() > 0; i++) step(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) obj_mem[i] = 29'd0;
  endtask

  task automatic set_slot(input int n, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] code, input logic [4:0] attr);
    obj_mem[n] = {attr, code, y, x};
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; line_start = 1'b1; V = 8'd0; out_ready = 1'b0;
    clear_mem();

    // Reset dominates line_start.
    for (int i = 0; i < 3; i++) step(1'b1, 8'd50, 1'b1, 1'b1, 1'b1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(scan_busy), 32'd0);

    // Single hit at slot 0, row 5.
    set_slot(0, 8'd20, 8'd100, 8'h35, 5'h03);
    dut_pops = 0;
    step(1'b1, 8'd105, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    check("lat_not_yet", 32'(out_valid), 32'd0);
    step(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("single_row", 32'(out_row), 32'd5);
    check("single_code", 32'(out_code), 32'h35);
    run(254, 1, 1'b0);
    check("busy_257", 32'(scan_busy), 32'd1);
    step(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    check("busy_end", 32'(scan_busy), 32'd0);
    run(3, 1, 1'b0);
    check("single_pops", 32'(dut_pops), 32'd1);

    // Vertical flip across the 255->0 wrap, then a span that just misses.
    clear_mem();
    set_slot(7, 8'd1, 8'd250, 8'h77, 5'h10);
    step(1'b1, 8'd3, 1'b0, 1'b1, 1'b0);
    run(260, 0, 1'b0);
    check("vflip_valid", 32'(out_valid), 32'd1);
    check("vflip_row", 32'(out_row), 32'd6);
    step(1'b1, 8'd10, 1'b0, 1'b1, 1'b0);
    run(260, 0, 1'b0);
    check("edge_nohit", 32'(out_valid), 32'd0);

    // Overflow: ten hits, no drain.
    clear_mem();
    for (int i = 0; i < 10; i++) set_slot(3 + 17 * i, 8'(10 + i), 8'd60, 8'(i), 5'(i));
    step(1'b1, 8'd64, 1'b0, 1'b1, 1'b0);
    run(260, 0, 1'b0);
    check("ovf_set", 32'(ovf), 32'd1);
    dut_pops = 0;
    drain();
    check("ovf_pops", 32'(dut_pops), 32'(DEPTH));
    step(1'b1, 8'd0, 1'b0, 1'b1, 1'b0);
    check("ovf_clear", 32'(ovf), 32'd0);
    run(260, 0, 1'b0);

    // Backpressure with ready toggling each cen.
    clear_mem();
    set_slot(40, 8'd5, 8'd30, 8'hA1, 5'h01);
    set_slot(41, 8'd6, 8'd31, 8'hA2, 5'h12);
    set_slot(90, 8'd7, 8'd25, 8'hA3, 5'h04);
    dut_pops = 0;
    step(1'b1, 8'd35, 1'b0, 1'b1, 1'b0);
    run(270, 2, 1'b0);
    check("bp_pops", 32'(dut_pops), 32'd3);

    // Restart mid-scan with entries queued, then reset mid-scan.
    clear_mem();
    set_slot(5, 8'd9, 8'd70, 8'h11, 5'h00);
    set_slot(30, 8'd9, 8'd71, 8'h12, 5'h10);
    set_slot(150, 8'd9, 8'd200, 8'h13, 5'h02);
    step(1'b1, 8'd72, 1'b0, 1'b1, 1'b0);
    run(101, 0, 1'b0);
    check("restart_q", 32'(out_valid), 32'd1);
    step(1'b1, 8'd205, 1'b1, 1'b1, 1'b0);
    check("restart_empty", 32'(out_valid), 32'd0);
    check("restart_addr", 32'(obj_addr), 32'd0);
    run(260, 0, 1'b0);
    step(1'b1, 8'd72, 1'b0, 1'b1, 1'b0);
    run(50, 0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    check("rst_mid_busy", 32'(scan_busy), 32'd0);
    run(5, 1, 1'b0);

    // Randomized lines: random table, ready, cen and occasional restarts.
    for (int l = 0; l < 14; l++) begin
      for (int i = 0; i < 256; i++)
        obj_mem[i] = {5'($urandom), 8'($urandom), 8'($urandom),
                      ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255))};
      step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        run($urandom_range(1, 200), 3, 1'b1);
        step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      end
      run(300, 3, 1'b1);
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtpopeye_obj_scan.md
Name: jtpopeye_obj_scan

Overview:
- Sprite line scanner directly downstream of the object DMA buffer.
- At the start of every line it walks all 256 object slots in the 29-bit object buffer and selects the objects whose vertical span covers the next line.
- Selected objects are queued in a small FIFO and handed to the sprite drawer over a valid/ready handshake.

Parameters:
- DEPTH, 8, FIFO entries (maximum objects per line); power of two, 2..16.
- OBJ_H, 16, object height in lines; power of two, at most 16.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- cen  in  1  clock enable; all state advances only on clk edges with cen=1.
- line_start  in  1  one-cen pulse at line start; V is valid with it.
- V  in  8  line number to prepare.
- obj_addr  out  8  object slot read address into the object buffer.
- obj_data  in  29  object word; valid one cen after obj_addr. Fields:
  - [7:0] x; x==0 means slot disabled.
  - [15:8] y.
  - [23:16] code.
  - [28:24] attr; attr[4] is vflip.
- out_valid  out  1  FIFO head holds an object.
- out_ready  in  1  drawer accepts the head.
- out_x  out  8  head x.
- out_code  out  8  head code.
- out_attr  out  5  head attr, passed through unchanged.
- out_row  out  4  row inside the object, already flipped.
- scan_busy  out  1  scan in progress.
- ovf  out  1  more than DEPTH objects hit on this line.

Behaviour:
- Reset (rst=1 at any clk edge, cen ignored): state IDLE, obj_addr=0, FIFO empty, out_valid=0, scan_busy=0, ovf=0. Reset mid-scan aborts the scan immediately.
- State IDLE: obj_addr is held. On line_start:
  - latch V into Vl; clear FIFO and ovf; obj_addr<=0; scan_busy<=1; go to SCAN.
- State SCAN: obj_addr increments each cen, stopping at 255; it does not wrap.
- Evaluate pipeline: a valid flag and a slot-number register follow each address through the 2-stage pipeline.
  - diff = (Vl - y) mod 256, 8-bit.
  - hit = (x!=0) && (diff < OBJ_H).
  - row = attr[4] ? ~diff[3:0] : diff[3:0], masked to log2(OBJ_H) bits.
  - For OBJ_H < 16, the unused upper row bits are 0.
- Latency: slot n address is driven at cen k. Its data is present at cen k+1, and a hit is written into the FIFO at the edge ending cen k+1. Consequence: a hit at slot 0 gives out_valid=1 two cen after the line_start edge.
- Scan end: after slot 255 is evaluated, scan_busy<=0 and the state returns to IDLE. scan_busy is high for exactly 257 cen edges after line_start.
- FIFO full on a hit: that hit is dropped, ovf<=1, the scan stops at once (scan_busy<=0, IDLE), and the FIFO contents are kept. ovf stays set until the next line_start or rst.
- Handshake:
  - A pop occurs on a cen edge with out_valid && out_ready.
  - out_* outputs are the registered head entry and are stable while out_valid=1 and not popped.
  - Push and pop in the same cen are both performed and the count is unchanged.
  - When full, a same-cycle pop frees the slot, so the hit is accepted and ovf is not set.
- line_start during SCAN: abort the scan, clear FIFO and ovf, restart from slot 0 with the new V. A pop in that same cycle is discarded.
- line_start and rst together: rst wins.
- Ordering: the FIFO preserves ascending slot order.

Test Plan:
- Reset: hold rst=1 three edges with cen=1 and line_start=1 → out_valid=0, scan_busy=0, ovf=0, obj_addr=0.
- Single hit, no flip: slot 0 = {x=20, y=100, code=0x35, attr=0x03}, all other slots x=0; V=105, out_ready=1 → out_valid rises 2 cen after line_start, out_row=5, out_code=0x35; exactly one pop; scan_busy low after 257 cen.
- Vflip and wrap: slot 7 = {x=1, y=250, attr=0x10}; V=3 → diff=9, out_row=6. Same slot with V=10 → diff=16, no hit.
- Overflow: 10 slots hit, out_ready=0, DEPTH=8 → 8 entries in ascending slot order, ovf=1 at the 9th hit, scan_busy drops on that edge; ovf clears on the next line_start.
- Backpressure: 3 hits, out_ready toggled 1-0-1 per cen → each entry is held stable while not ready, all 3 delivered once, in order.
- Restart: pulse line_start at slot 100 of a scan with 2 entries queued → FIFO empty the next cycle, obj_addr=0, new V used; rst mid-scan → IDLE on the next edge.
